dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data RAM between two requesters:
  - M0 is the CPU MEM stage load/store port.
  - M1 is the debug/program-loader port, used for testbench preload and register-dump helpers.
- Arbitration is round-robin, with an optional lock for atomic multi-beat sequences.
- Tracks in-flight reads through a fixed-latency return pipe and steers read data back to the owning master.
- Sits between CPU_TOP's MEM stage and the DRAM macro; M0 stall is derived from its grant.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_rd_pipe.sv | 29 ++
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter slice.
// Arbiter FSM states, read-return tags and master indices.
package dmem_pkg;

  typedef enum logic [1:0] {
    ARB,
    LOCK0,
    LOCK1
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/dmem_rd_pipe.sv
// Fixed-latency read-return tracker.
// Carries {valid, owner} alongside the RAM read latency.
module dmem_rd_pipe
  import dmem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_pipe [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++)
        r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < RD_LAT; i++)
        r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tag = r_pipe[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the single-port data RAM.
// Supports locked multi-beat sequences and steers read returns.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  arb_state_e r_state;
  logic       r_rr_last;

  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_any;
  logic       w_sel;
  logic       w_we;
  logic       w_lock;
  logic [3:0] w_wstrb;
  rd_tag_t    w_push;
  rd_tag_t    w_pop;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    unique case (r_state)
      ARB: begin
        if (m0_req && m1_req) begin
          w_gnt0 = (r_rr_last == M1);
          w_gnt1 = (r_rr_last == M0);
        end else begin
          w_gnt0 = m0_req;
          w_gnt1 = m1_req;
        end
      end
      LOCK0: w_gnt0 = m0_req;
      LOCK1: w_gnt1 = m1_req;
      default: ;
    endcase
    if (rst) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign w_any   = w_gnt0 | w_gnt1;
  assign w_sel   = w_gnt1;
  assign w_we    = w_sel ? m1_we    : m0_we;
  assign w_lock  = w_sel ? m1_lock  : m0_lock;
  assign w_wstrb = w_sel ? m1_wstrb : m0_wstrb;

  // Lock is dropped on an unlocked beat or a gap in the owner's req.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB;
      r_rr_last <= M1;
    end else begin
      if (w_any)
        r_rr_last <= w_sel;
      unique case (r_state)
        ARB: begin
          if (w_any && w_lock)
            r_state <= w_sel ? LOCK1 : LOCK0;
        end
        LOCK0: begin
          if (!m0_req || !m0_lock)
            r_state <= ARB;
        end
        LOCK1: begin
          if (!m1_req || !m1_lock)
            r_state <= ARB;
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign ram_en    = w_any;
  assign ram_we    = (w_any && w_we) ? w_wstrb : 4'b0000;
  assign ram_addr  = w_sel ? m1_addr[ADDR_W+1:2]
                           : m0_addr[ADDR_W+1:2];
  assign ram_wdata = w_sel ? m1_wdata : m0_wdata;

  assign w_push.valid = w_any & ~w_we;
  assign w_push.owner = w_sel;

  dmem_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_tag (w_push),
    .o_tag (w_pop)
  );

  assign m0_rvalid = w_pop.valid & (w_pop.owner == M0);
  assign m1_rvalid = w_pop.valid & (w_pop.owner == M1);
  assign m0_rdata  = m0_rvalid ? ram_rdata : 32'h0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : 32'h0;

  logic w_unused_addr;
  assign w_unused_addr = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                           m1_addr[31:ADDR_W+2], m1_addr[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with RD_LAT=1 and RD_LAT=3 instances.
// Read returns are matched against a queue filled as requests are driven.
module tb_dmem_arbiter;

  typedef struct {
    logic        owner;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst1, rst3;

  logic        m0_req, m0_we, m0_lock;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m1_req, m1_we, m1_lock;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_wstrb;

  logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
  logic [31:0] a_m0_rdata, a_m1_rdata;
  logic        a_ram_en;
  logic [3:0]  a_ram_we;
  logic [11:0] a_ram_addr;
  logic [31:0] a_ram_wdata, a_ram_rdata;

  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_ram_en;
  logic [3:0]  b_ram_we;
  logic [11:0] b_ram_addr;
  logic [31:0] b_ram_wdata, b_ram_rdata;

  logic        ld_en;
  logic        ld_m;
  logic [11:0] ld_a;
  logic [31:0] ld_d;

  logic [31:0] mem1 [0:4095];
  logic [31:0] mem3 [0:4095];
  logic [31:0] p3_0, p3_1;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;
  int   total = 0;
  int   bad   = 0;

  dmem_arbiter #(.ADDR_W(12), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst1),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
    .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata)
  );

  dmem_arbiter #(.ADDR_W(12), .RD_LAT(3)) u3 (
    .clk(clk), .rst(rst3),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Write-first RAM models, one per latency.
  always @(posedge clk) begin
    if (ld_en && !ld_m)
      mem1[ld_a] <= ld_d;
    else if (a_ram_en)
      mem1[a_ram_addr] <= merge(mem1[a_ram_addr], a_ram_wdata, a_ram_we);
    a_ram_rdata <= merge(mem1[a_ram_addr], a_ram_wdata, a_ram_we);
  end

  always @(posedge clk) begin
    if (ld_en && ld_m)
      mem3[ld_a] <= ld_d;
    else if (b_ram_en)
      mem3[b_ram_addr] <= merge(mem3[b_ram_addr], b_ram_wdata, b_ram_we);
    p3_0        <= merge(mem3[b_ram_addr], b_ram_wdata, b_ram_we);
    p3_1        <= p3_0;
    b_ram_rdata <= p3_1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic m, input logic [11:0] a,
                      input logic [31:0] d);
    ld_en = 1'b1;
    ld_m  = m;
    ld_a  = a;
    ld_d  = d;
    tick();
    ld_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (a_m0_rvalid || a_m1_rvalid) begin
      chk("u1_pending", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("u1_m0_rvalid", 32'(a_m0_rvalid), 32'(!e1.owner));
        chk("u1_m1_rvalid", 32'(a_m1_rvalid), 32'(e1.owner));
        chk("u1_rdata", e1.owner ? a_m1_rdata : a_m0_rdata, e1.data);
        chk("u1_other_rdata", e1.owner ? a_m0_rdata : a_m1_rdata, 32'h0);
      end
    end
  end

  always @(negedge clk) begin
    if (b_m0_rvalid || b_m1_rvalid) begin
      chk("u3_pending", 32'(q3.size() != 0), 32'd1);
      if (q3.size() != 0) begin
        e3 = q3.pop_front();
        chk("u3_m0_rvalid", 32'(b_m0_rvalid), 32'(!e3.owner));
        chk("u3_m1_rvalid", 32'(b_m1_rvalid), 32'(e3.owner));
        chk("u3_rdata", e3.owner ? b_m1_rdata : b_m0_rdata, e3.data);
      end
    end
  end

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; ld_en = 1'b0; ld_m = 1'b0;
    ld_a = '0; ld_d = '0;
    m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0;
    m0_addr = 32'h10; m0_wdata = '0; m0_wstrb = 4'hF;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0;
    m1_addr = '0; m1_wdata = '0; m1_wstrb = 4'hF;
    tick();
    load(1'b0, 12'd4,  32'hDEADBEEF);
    load(1'b0, 12'd8,  32'hAABBCCDD);
    load(1'b0, 12'd16, 32'h00000100);
    load(1'b0, 12'd32, 32'h00000200);
    load(1'b1, 12'd4,  32'h0000C0C0);
    load(1'b1, 12'd5,  32'h0000C1C1);
    load(1'b1, 12'd6,  32'h0000C2C2);

    // reset: grants forced low even with req held
    @(negedge clk);
    chk("rst_m0_gnt", 32'(a_m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(a_m1_gnt), 32'd0);
    chk("rst_ram_en", 32'(a_ram_en), 32'd0);
    chk("rst_ram_we", 32'(a_ram_we), 32'd0);
    chk("rst_m0_rvalid", 32'(a_m0_rvalid), 32'd0);
    chk("rst_m0_rdata", a_m0_rdata, 32'd0);

    // single M0 read
    tick();
    rst1 = 1'b0;
    q1.push_back('{1'b0, 32'hDEADBEEF});
    @(negedge clk);
    chk("t1_m0_gnt", 32'(a_m0_gnt), 32'd1);
    chk("t1_m1_gnt", 32'(a_m1_gnt), 32'd0);
    chk("t1_ram_addr", 32'(a_ram_addr), 32'd4);
    chk("t1_ram_we", 32'(a_ram_we), 32'd0);
    tick();
    m0_req = 1'b0;
    @(negedge clk);
    chk("t1_rvalid", 32'(a_m0_rvalid), 32'd1);

    // lone M1 read leaves rr_last at M1
    tick();
    m1_req = 1'b1; m1_addr = 32'h80;
    q1.push_back('{1'b1, 32'h200});
    @(negedge clk);
    chk("t2_pre_m1_gnt", 32'(a_m1_gnt), 32'd1);

    // both requesting: M0, M1, M0, M1
    for (int i = 0; i < 4; i++) begin
      tick();
      m0_req = 1'b1; m0_addr = 32'h40;
      q1.push_back('{i[0], i[0] ? 32'h200 : 32'h100});
      @(negedge clk);
      chk("t2_m0_gnt", 32'(a_m0_gnt), 32'(!i[0]));
      chk("t2_m1_gnt", 32'(a_m1_gnt), 32'(i[0]));
      chk("t2_ram_addr", 32'(a_ram_addr), i[0] ? 32'd32 : 32'd16);
    end

    // partial write then read-after-write
    tick();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20;
    m1_wdata = 32'h11223344; m1_wstrb = 4'b0011;
    @(negedge clk);
    chk("t3_m1_gnt", 32'(a_m1_gnt), 32'd1);
    chk("t3_ram_we", 32'(a_ram_we), 32'b0011);
    chk("t3_ram_wdata", a_ram_wdata, 32'h11223344);
    chk("t3_ram_addr", 32'(a_ram_addr), 32'd8);
    tick();
    m1_req = 1'b0; m1_we = 1'b0; m1_wstrb = 4'hF;
    m0_req = 1'b1; m0_addr = 32'h20;
    q1.push_back('{1'b0, 32'hAABB3344});
    @(negedge clk);
    chk("t3_m0_gnt", 32'(a_m0_gnt), 32'd1);

    // M1 locked for 3 beats plus a final unlocked beat
    for (int i = 0; i < 4; i++) begin
      tick();
      m0_addr = 32'h10;
      m1_req = 1'b1; m1_addr = 32'h80; m1_lock = (i < 3);
      q1.push_back('{1'b1, 32'h200});
      @(negedge clk);
      chk("t4_m0_gnt", 32'(a_m0_gnt), 32'd0);
      chk("t4_m1_gnt", 32'(a_m1_gnt), 32'd1);
    end
    tick();
    m1_req = 1'b0; m1_lock = 1'b0;
    q1.push_back('{1'b0, 32'hDEADBEEF});
    @(negedge clk);
    chk("t4_m0_after", 32'(a_m0_gnt), 32'd1);

    // M0 lock released by a req gap
    tick();
    m0_lock = 1'b1;
    q1.push_back('{1'b0, 32'hDEADBEEF});
    @(negedge clk);
    chk("t5_m0_lock_gnt", 32'(a_m0_gnt), 32'd1);
    tick();
    m0_req = 1'b0; m0_lock = 1'b0; m1_req = 1'b1;
    @(negedge clk);
    chk("t5_m1_locked_out", 32'(a_m1_gnt), 32'd0);
    tick();
    q1.push_back('{1'b1, 32'h200});
    @(negedge clk);
    chk("t5_m1_released", 32'(a_m1_gnt), 32'd1);

    // zero-strobe write still takes the slot
    tick();
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_wstrb = 4'b0000; m0_addr = 32'h40;
    @(negedge clk);
    chk("t6_m0_gnt", 32'(a_m0_gnt), 32'd1);
    chk("t6_ram_en", 32'(a_ram_en), 32'd1);
    chk("t6_ram_we", 32'(a_ram_we), 32'd0);
    tick();
    m0_req = 1'b0; m0_we = 1'b0; m0_wstrb = 4'hF;
    repeat (2) @(negedge clk);
    chk("u1_drained", 32'(q1.size()), 32'd0);

    // RD_LAT=3 instance: reads at cycles 0..2, reset at cycle 4
    tick();
    rst1 = 1'b1; rst3 = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h10;
    q3.push_back('{1'b0, 32'h0000C0C0});
    @(negedge clk);
    chk("t7_m0_gnt", 32'(b_m0_gnt), 32'd1);
    chk("t7_ram_addr", 32'(b_ram_addr), 32'd4);
    tick();
    m0_addr = 32'h14;
    q3.push_back('{1'b0, 32'h0000C1C1});
    tick();
    m0_addr = 32'h18;
    q3.push_back('{1'b0, 32'h0000C2C2});
    tick();
    m0_req = 1'b0;
    @(negedge clk);
    chk("t7_rvalid_c3", 32'(b_m0_rvalid), 32'd1);
    tick();
    rst3 = 1'b1;
    @(negedge clk);
    chk("t7_rvalid_c4", 32'(b_m0_rvalid), 32'd1);
    #1;
    q3.delete();
    tick();
    m0_req = 1'b1;
    @(negedge clk);
    chk("t7_rst_rvalid", 32'(b_m0_rvalid), 32'd0);
    chk("t7_rst_rdata", b_m0_rdata, 32'd0);
    chk("t7_rst_m1_rvalid", 32'(b_m1_rvalid), 32'd0);
    chk("t7_rst_gnt", 32'(b_m0_gnt), 32'd0);
    chk("t7_rst_ram_en", 32'(b_ram_en), 32'd0);
    chk("t7_rst_ram_we", 32'(b_ram_we), 32'd0);
    tick();
    m0_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
